// File: rtl/ram_bus_master_pkg.sv
// Shared definitions for the CPU-side RAM bus master: bus width and the
// state encoding, exported so monitors and benches can decode the state.
package ram_bus_master_pkg;

    localparam int ARCH_BITS = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_AHOLD = 3'd2;
    localparam logic [2:0] ST_WSET  = 3'd3;
    localparam logic [2:0] ST_WHOLD = 3'd4;
    localparam logic [2:0] ST_RENA  = 3'd5;
    localparam logic [2:0] ST_RDONE = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ADDR  = ST_ADDR,
        S_AHOLD = ST_AHOLD,
        S_WSET  = ST_WSET,
        S_WHOLD = ST_WHOLD,
        S_RENA  = ST_RENA,
        S_RDONE = ST_RDONE
    } state_e;

endpackage

// File: rtl/ram_bus_master.sv
// Single-word RAM bus initiator: turns client read/write requests into the
// MAR-set / write-strobe / output-enable sequence on the shared RAM bus.
module ram_bus_master #(
    parameter int ARCH_BITS = ram_bus_master_pkg::ARCH_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ARCH_BITS-1:0] req_addr,
    input  logic [ARCH_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [ARCH_BITS-1:0] rsp_rdata,
    output logic [ARCH_BITS-1:0] ram_bas,
    output logic                 ram_wsa,
    inout  wire  [ARCH_BITS-1:0] ram_bio,
    output logic                 ram_ws,
    output logic                 ram_we
);

    import ram_bus_master_pkg::*;

    state_e                r_state;
    state_e                w_next;
    logic                  w_handshake;

    logic                  r_write;
    logic [ARCH_BITS-1:0]  r_wdata;
    logic [ARCH_BITS-1:0]  r_bas;
    logic [ARCH_BITS-1:0]  r_rdata;
    logic                  r_wsa;
    logic                  r_ws;
    logic                  r_we;
    logic                  r_rsp_valid;
    logic                  r_drive;

    assign w_handshake = req_valid && (r_state == S_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = S_ADDR;
            S_ADDR:  w_next = S_AHOLD;
            S_AHOLD: w_next = r_write ? S_WSET : S_RENA;
            S_WSET:  w_next = S_WHOLD;
            S_WHOLD: w_next = S_IDLE;
            S_RENA:  w_next = S_RDONE;
            S_RDONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_handshake) begin
            r_write <= req_write;
            r_wdata <= req_wdata;
        end
    end

    // Strobes are decoded from the next state so each one is a clean flop
    // output that is valid for the whole cycle of the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsa       <= 1'b0;
            r_ws        <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_drive     <= 1'b0;
        end else begin
            r_wsa       <= (w_next == S_ADDR);
            r_ws        <= (w_next == S_WSET);
            r_we        <= (w_next == S_RENA);
            r_rsp_valid <= (w_next == S_WHOLD) || (w_next == S_RDONE);
            r_drive     <= (w_next == S_WSET) || (w_next == S_WHOLD);
        end
    end

    // The address bus keeps the last address between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bas <= '0;
        end else if (w_handshake) begin
            r_bas <= req_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == S_RENA) begin
            r_rdata <= ram_bio;
        end
    end

    assign ram_bio   = r_drive ? r_wdata : 'z;
    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign ram_bas   = r_bas;
    assign ram_wsa   = r_wsa;
    assign ram_ws    = r_ws;
    assign ram_we    = r_we;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: RAM responder on the bus, a per-access timeline
// model compared every cycle, and directed accesses with literal expectations.
module tb_ram_bus_master;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_write = 1'b0;
    logic [W-1:0] req_addr = '0;
    logic [W-1:0] req_wdata = '0;
    wire          req_ready;
    wire          rsp_valid;
    wire  [W-1:0] rsp_rdata;
    wire  [W-1:0] ram_bas;
    wire          ram_wsa;
    wire          ram_ws;
    wire          ram_we;
    wire  [W-1:0] ram_bio;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ram_bus_master #(.ARCH_BITS(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_bas   (ram_bas),
        .ram_wsa   (ram_wsa),
        .ram_bio   (ram_bio),
        .ram_ws    (ram_ws),
        .ram_we    (ram_we)
    );

    // RAM responder: MAR latched on wsa, write on ws, drives bus while we.
    logic [W-1:0] ram_mem [256];
    logic [W-1:0] ram_mar = '0;
    always @(posedge clk) begin
        if (ram_wsa) ram_mar <= ram_bas;
        if (ram_ws)  ram_mem[ram_mar] <= ram_bio;
    end
    assign ram_bio = ram_we ? ram_mem[ram_mar] : 'z;

    // Model: an accepted request occupies phases 1..4 after the handshake,
    // then the master is idle again (phase 0).
    int           m_phase = 0;
    logic         m_write = 1'b0;
    logic [W-1:0] m_bas = '0;
    logic [W-1:0] m_wdata = '0;
    logic [W-1:0] m_rdata = '0;
    logic [W-1:0] model_mem [256];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_bas   <= '0;
            m_rdata <= '0;
        end else begin
            if (m_phase == 0) begin
                if (req_valid) begin
                    m_phase <= 1;
                    m_write <= req_write;
                    m_bas   <= req_addr;
                    m_wdata <= req_wdata;
                end
            end else begin
                m_phase <= (m_phase == 4) ? 0 : m_phase + 1;
            end
            if (m_phase == 3) begin
                if (m_write) model_mem[m_bas] <= m_wdata;
                else         m_rdata <= model_mem[m_bas];
            end
        end
    end

    int cyc = 0;
    int last_hs = 0;
    int hs_q[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req_valid && req_ready) begin
            hs_q.push_back(cyc);
            last_hs <= cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bus_free();
        return (ram_bio === '0) || $isunknown(ram_bio);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", req_ready, m_phase == 0);
            check("bas", ram_bas, m_bas);
            check("wsa", ram_wsa, m_phase == 1);
            check("ws", ram_ws, (m_phase == 3) && m_write);
            check("we", ram_we, (m_phase == 3) && !m_write);
            check("rsp_valid", rsp_valid, m_phase == 4);
            check("rdata", rsp_rdata, m_rdata);
            check("one_strobe", (32'(ram_wsa) + 32'(ram_ws) + 32'(ram_we)) <= 1, 1);
            if (m_write && (m_phase == 3 || m_phase == 4))
                check("bio_wr", ram_bio, m_wdata);
            else if (m_phase == 3)
                check("bio_rd", ram_bio, model_mem[m_bas]);
            else
                check("bio_free", bus_free(), 1);
        end
    end

    // Present a request and hold it until the handshake edge has passed.
    task automatic do_req(input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_timeout", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", rsp_valid, 1);
        lat = cyc - last_hs;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wsa"}, ram_wsa, 0);
        check({tag, "_ws"}, ram_ws, 0);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_bas"}, ram_bas, 0);
        check({tag, "_rdata"}, rsp_rdata, 0);
        check({tag, "_bio_free"}, bus_free(), 1);
    endtask

    initial begin
        int lat;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        check("por_ready", req_ready, 1);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // Write 0xA5 to 0x3C, then read it back with 4-cycle latency.
        do_req(1'b1, 8'h3C, 8'hA5);
        @(posedge clk); @(posedge clk); #2;
        check("wr_ws", ram_ws, 1);
        check("wr_bio", ram_bio, 8'hA5);
        check("wr_bas", ram_bas, 8'h3C);
        wait_rsp(lat);
        check("wr_latency", lat, 4);
        do_req(1'b0, 8'h3C, 8'h00);
        wait_rsp(lat);
        check("rd_latency", lat, 4);
        check("rd_3c", rsp_rdata, 8'hA5);

        // Address extremes, no aliasing.
        do_req(1'b1, 8'h00, 8'h01);
        wait_rsp(lat);
        do_req(1'b1, 8'hFF, 8'hFE);
        wait_rsp(lat);
        do_req(1'b0, 8'h00, 8'h00);
        wait_rsp(lat);
        check("rd_00", rsp_rdata, 8'h01);
        do_req(1'b0, 8'hFF, 8'h00);
        wait_rsp(lat);
        check("rd_ff", rsp_rdata, 8'hFE);

        // Back-to-back reads with req_valid held high.
        hs_q.delete();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            int n;
            n = 0;
            while (!req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_ready", req_ready, 1);
            @(posedge clk);
            #1;
            req_addr = (k == 0) ? 8'h00 : 8'hFF;
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check("b2b_gap1", hs_q[1] - hs_q[0], 5);
            check("b2b_gap2", hs_q[2] - hs_q[1], 5);
        end
        check("b2b_last_rdata", rsp_rdata, 8'hFE);

        do_req(1'b1, 8'h10, 8'h5A);
        wait_rsp(lat);

        // Reset during WSET.
        do_req(1'b1, 8'h20, 8'h77);
        @(posedge clk); @(posedge clk); #2;
        check("midwr_ws_before", ram_ws, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwr");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("midwr_ready_after", req_ready, 1);

        // Reset during RENA, then read 0x10 again.
        do_req(1'b0, 8'h3C, 8'h00);
        wait_rsp(lat);
        check("pre_rd_3c", rsp_rdata, 8'hA5);
        do_req(1'b0, 8'h10, 8'h00);
        @(posedge clk); @(posedge clk); #2;
        check("midrd_we_before", ram_we, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrd");
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_req(1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("rd_10_pending", rsp_rdata, 8'h00);
        wait_rsp(lat);
        check("rd_10", rsp_rdata, 8'h5A);
        check("rd_10_latency", lat, 4);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Initiator for the CPU-side memory bus. It converts single-word read/write requests from a client (e.g. the control stepper) into the RAM strobe sequence: address bus plus MAR set strobe, then data-bus write strobe or data-bus enable. It owns the address bus and the RAM strobes, and it drives the shared bidirectional data bus only while it is writing. It sits between the sequencing logic and the RAM responder, which latches the address on `wsa`, writes on `ws` and drives the data bus while `we` is high.

## Interface
- `ARCH_BITS`, default 8: address and data width, taken from the shared defs.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — client request present.
- `req_ready`  out  1  — master can accept; high only in IDLE.
- `req_write`  in  1  — 1 = write, 0 = read.
- `req_addr`  in  ARCH_BITS  — word address.
- `req_wdata`  in  ARCH_BITS  — write data.
- `rsp_valid`  out  1  — one-cycle completion pulse, for reads and writes.
- `rsp_rdata`  out  ARCH_BITS  — read data; valid when `rsp_valid` is high on a read; holds its value until the next read completes.
- `ram_bas`  out  ARCH_BITS  — address bus to the MAR.
- `ram_wsa`  out  1  — MAR set strobe.
- `ram_bio`  inout  ARCH_BITS  — shared data bus; high-Z unless writing.
- `ram_ws`  out  1  — RAM write strobe.
- `ram_we`  out  1  — RAM output enable.

## Operation
- A handshake occurs when `req_valid` and `req_ready` are both high at a rising edge. On that edge the master captures `req_write`, `req_addr` and `req_wdata`. The client may change its inputs on the next cycle.
- States are IDLE, ADDR, AHOLD, WSET, WHOLD, RENA and RDONE.
- IDLE: `req_ready` = 1 and all strobes = 0. `ram_bio` is Z and `ram_bas` holds its last value. On a handshake the next state is ADDR.
- ADDR: `ram_bas` = captured address and `ram_wsa` = 1. Next state is AHOLD.
- AHOLD: `ram_bas` is held and `ram_wsa` = 0, so the address is stable across the falling edge of the MAR strobe. Next state is WSET for a write, RENA for a read.
- WSET: `ram_bio` = captured data and `ram_ws` = 1. Next state is WHOLD.
- WHOLD: `ram_bio` is still driven and `ram_ws` = 0, giving data hold past the strobe's falling edge. `rsp_valid` = 1. Next state is IDLE.
- RENA: `ram_we` = 1 and `ram_bio` is Z. `ram_bio` is sampled into `rsp_rdata` at the rising edge that ends RENA. Next state is RDONE.
- RDONE: `ram_we` = 0 and `rsp_valid` = 1. Next state is IDLE.
- Bus contention: the master never drives `ram_bio` in the same cycle as `ram_we` = 1. At most one of `ram_wsa`, `ram_ws`, `ram_we` is high in any cycle.
- Address arithmetic: none. The address is passed through at full ARCH_BITS width, so every address from 0 to 2^ARCH_BITS−1 is reachable.
- Reset, asserted at any time including mid-access:
  - state goes to IDLE;
  - `ram_wsa`, `ram_ws`, `ram_we`, `rsp_valid` go to 0;
  - `ram_bio` goes to Z;
  - `ram_bas` and `rsp_rdata` go to 0;
  - the in-flight request is dropped and no `rsp_valid` is produced for it.
- `req_valid` arriving in any state other than IDLE is ignored, because `req_ready` = 0. It is accepted when the master returns to IDLE.

## Timing
- Outputs are registered from state. The strobe and bus values listed for a state are valid for the whole cycle the master is in that state.
- Latency from the handshake edge to `rsp_valid` high is 4 cycles for both reads and writes (ADDR, AHOLD, WSET/RENA, WHOLD/RDONE). `rsp_valid` is high in the fourth cycle.
- `req_ready` returns high in the cycle after `rsp_valid`. Peak throughput is therefore one access per 5 cycles.
- Read data is available on `rsp_rdata` in the same cycle as `rsp_valid`.

## Structure
- The state encoding, as localparams for the 7 states, goes in the shared defs file next to `ARCH_BITS`, so the debug monitor and the benches can decode the state.
- There is a single module with no sub-module. The tristate on `ram_bio` is one continuous assign from a registered drive-enable and a registered data value.

## Test plan
- Write then read: write 0xA5 to 0x3C, then read 0x3C → `ram_bas` = 0x3C while `ram_wsa` pulses; `ram_ws` is high one cycle with `ram_bio` = 0xA5; the read gives `rsp_rdata` = 0xA5 with `rsp_valid` 4 cycles after the handshake.
- Address extremes: write 0x01 to 0x00 and 0xFE to 0xFF, then read both → 0x01 and 0xFE, with no aliasing.
- Back-to-back requests: hold `req_valid` high for 3 requests → `req_ready` is high only in IDLE, and handshakes are exactly 5 cycles apart.
- Bus checker every cycle: `ram_bio` is never driven while `ram_we` = 1, and no two of `ram_wsa`, `ram_ws`, `ram_we` are high together.
- Reset mid-write: assert `rst_n` = 0 during WSET → all strobes go to 0 and `ram_bio` goes to Z immediately; no `rsp_valid`; after release, `req_ready` = 1.
- Reset mid-read: assert reset during RENA, then read 0x10 (previously written 0x5A) → `rsp_rdata` is 0x00 until that read completes, then 0x5A.
